mp_addsub_seq: RTL and testbench
================================

MP_ADDSUB_SEQ -- requirements
Module: mp_addsub_seq

Interface
REQ-001 SHALL have CLK, input, 1, sole clock; all state on rising edge.
REQ-002 SHALL have RSTN, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have START, input, 1, operation request; sampled only when BUSY=0.
REQ-004 SHALL have OP, input, 3, opcode latched on accepted START.
REQ-005 SHALL have LEN, input, 2, operand length in 16-bit words minus one (0..3 = 16..64 bits), latched on accepted START.
REQ-006 SHALL have A, input, 64, operand A, word 0 = bits 15:0, latched on accepted START.
REQ-007 SHALL have B, input, 64, operand B, latched on accepted START.
REQ-008 SHALL have BUSY, output, 1, high from cycle after accepted START through the DONE cycle inclusive.
REQ-009 SHALL have DONE, output, 1, one-cycle pulse when Y and flags are final.
REQ-010 SHALL have Y, output, 64, result register.
REQ-011 SHALL have CF, output, 1, carry flag (carry out of last processed word; for subtract, 1 = no borrow).
REQ-012 SHALL have ZF, output, 1, zero flag over the processed words.
REQ-013 SHALL have NF, output, 1, bit 15 of the last processed word.

Function
REQ-014 SHALL contain one 16-bit add/sub/move/negate unit: y = (ENA ? a : 0) + (SUB ? ~b : b) + ci, co = carry out of bit 15.
REQ-015 SHALL decode OP to (ENA,SUB,word-0 ci): 0 MOV (0,0,0); 1 NEG (0,1,1); 2 ADD (1,0,0); 3 SUB (1,1,1); 4 INC (0,0,1); 5 NOT (0,1,0); 6 ADC (1,0,CF); 7 SBC (1,1,CF).
REQ-016 SHALL, for ADC/SBC, use the CF value held at START acceptance.
REQ-017 SHALL use as ci for words 1..LEN the co of the previous word (ripple across cycles).
REQ-018 SHALL implement states IDLE, RUN, FIN; IDLE->RUN on START with BUSY=0; RUN stays until word index = LEN is processed, then ->FIN; FIN->IDLE unconditionally after one cycle.
REQ-019 SHALL process exactly one word per RUN cycle, index starting at 0 and incrementing by 1.
REQ-020 SHALL clear Y to zero on START acceptance and write Y word i in the RUN cycle processing word i; words above LEN remain 0.
REQ-021 SHALL assert DONE only in FIN; DONE at the (LEN+2)th rising edge after the START-accept edge (LEN=0 -> 2 cycles, LEN=3 -> 5 cycles).
REQ-022 SHALL update CF, NF at the last RUN cycle; ZF = 1 iff all processed words are zero.
REQ-023 SHALL hold Y, CF, ZF, NF unchanged from FIN until the next accepted START.
REQ-024 SHALL ignore START while BUSY=1, including the FIN cycle; no queuing.
REQ-025 SHALL ignore changes on OP, LEN, A, B after acceptance.
REQ-026 SHALL treat Y, CF, ZF, NF as valid only when DONE=1 or in IDLE after a DONE.

Reset
REQ-027 SHALL, on RSTN low at any time including mid-RUN, force state IDLE, word index 0, BUSY=0, DONE=0, Y=0, CF=0, ZF=0, NF=0, discarding the operation.
REQ-028 SHALL accept START on the first rising edge with RSTN high.

Verification
REQ-029 SHALL cover: LEN=0, OP=ADD, A=6666, B=3333 -> DONE 2 cycles after START, Y=9999, CF=0, ZF=0, NF=0.
REQ-030 SHALL cover: LEN=3, OP=ADD, A=0x000000000000FFFF, B=1 -> Y=0x0000000000010000, CF=0, DONE after 5 cycles, BUSY high 5 cycles.
REQ-031 SHALL cover: LEN=3, OP=SUB, A=0, B=1 -> Y=0xFFFFFFFFFFFFFFFF, CF=0, NF=1, ZF=0; then LEN=1, OP=NEG, B=0 -> Y=0, CF=1, ZF=1.
REQ-032 SHALL cover: LEN=0, OP=ADD, A=0xFFFF, B=1 -> Y=0, CF=1, ZF=1; then OP=ADC, A=0, B=0 -> Y=1, CF=0; then OP=SBC, A=5, B=2 with CF=0 -> Y=2, CF=1.
REQ-033 SHALL cover: all eight OPs at LEN=0 with A=6666, B=3333, CF=0 -> Y = 3333, 0xF2FB, 9999, 3333, 3334, 0xF2FA, 9999, 3332.
REQ-034 SHALL cover: START pulsed each cycle during a LEN=3 op -> only first accepted; RSTN low in 2nd RUN cycle -> all outputs 0 immediately, IDLE, next START accepted normally.

Source files
------------

// File: rtl/mp_addsub_seq.sv
// Multi-precision add/sub/move/negate sequencer: one 16-bit word per cycle
// through a single adder, carry rippled across cycles, up to 64-bit operands.
module mp_addsub_seq (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [1:0]  len,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] y,
    output logic        cf,
    output logic        zf,
    output logic        nf
);

    // state | meaning
    // IDLE  | waiting for start; outputs hold the last result
    // RUN   | processing word idx through the 16-bit unit
    // FIN   | done pulse; result and flags final
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t      state, state_nxt;
    logic [1:0]  idx, len_r;
    logic [63:0] a_r, b_r;
    logic        ena_r, sub_r, carry, zacc;
    logic        dec_ena, dec_sub, dec_ci;
    logic        accept, last;
    logic [15:0] opa, opb;
    logic [16:0] sum;

    always_comb begin
        dec_ena = 1'b0;
        dec_sub = 1'b0;
        dec_ci  = 1'b0;
        case (op)
            3'd0: begin dec_ena = 1'b0; dec_sub = 1'b0; dec_ci = 1'b0; end
            3'd1: begin dec_ena = 1'b0; dec_sub = 1'b1; dec_ci = 1'b1; end
            3'd2: begin dec_ena = 1'b1; dec_sub = 1'b0; dec_ci = 1'b0; end
            3'd3: begin dec_ena = 1'b1; dec_sub = 1'b1; dec_ci = 1'b1; end
            3'd4: begin dec_ena = 1'b0; dec_sub = 1'b0; dec_ci = 1'b1; end
            3'd5: begin dec_ena = 1'b0; dec_sub = 1'b1; dec_ci = 1'b0; end
            3'd6: begin dec_ena = 1'b1; dec_sub = 1'b0; dec_ci = cf;   end
            default: begin dec_ena = 1'b1; dec_sub = 1'b1; dec_ci = cf; end
        endcase
    end

    assign accept = (state == IDLE) && start;
    assign last   = (idx == len_r);

    assign opa = ena_r ? a_r[{idx, 4'b0000} +: 16] : 16'h0000;
    assign opb = sub_r ? ~b_r[{idx, 4'b0000} +: 16] : b_r[{idx, 4'b0000} +: 16];
    assign sum = {1'b0, opa} + {1'b0, opb} + {16'h0000, carry};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == FIN);
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx   <= 2'd0;
            len_r <= 2'd0;
            a_r   <= 64'd0;
            b_r   <= 64'd0;
            ena_r <= 1'b0;
            sub_r <= 1'b0;
            carry <= 1'b0;
            zacc  <= 1'b0;
            y     <= 64'd0;
            cf    <= 1'b0;
            zf    <= 1'b0;
            nf    <= 1'b0;
        end else if (accept) begin
            idx   <= 2'd0;
            len_r <= len;
            a_r   <= a;
            b_r   <= b;
            ena_r <= dec_ena;
            sub_r <= dec_sub;
            carry <= dec_ci;
            zacc  <= 1'b1;
            y     <= 64'd0;
        end else if (state == RUN) begin
            y[{idx, 4'b0000} +: 16] <= sum[15:0];
            carry <= sum[16];
            zacc  <= zacc && (sum[15:0] == 16'h0000);
            if (last) begin
                cf <= sum[16];
                nf <= sum[15];
                zf <= zacc && (sum[15:0] == 16'h0000);
            end else begin
                idx <= idx + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_mp_addsub_seq.sv
// Self-checking bench for mp_addsub_seq: directed cases plus random operations
// compared against a whole-operand arithmetic model.
module tb_mp_addsub_seq;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [1:0]  len = 2'd0;
    logic [63:0] a = 64'd0;
    logic [63:0] b = 64'd0;
    logic        busy, done, cf, zf, nf;
    logic [63:0] y;

    int n_tests = 0;
    int n_fail  = 0;
    logic m_cf = 1'b0;

    mp_addsub_seq dut (
        .clk(clk), .rstn(rstn), .start(start), .op(op), .len(len), .a(a), .b(b),
        .busy(busy), .done(done), .y(y), .cf(cf), .zf(zf), .nf(nf)
    );

    always #5 clk = ~clk;

    // Returns {carry, zero, negative, result} for the whole n-bit operation.
    function automatic logic [66:0] model(input logic [2:0] o, input logic [1:0] l,
                                          input logic [63:0] av, input logic [63:0] bv,
                                          input logic cin);
        int          nb;
        logic [63:0] mask, ra;
        logic [64:0] s;
        logic        ena, sub, ci;
        nb   = (int'(l) + 1) * 16;
        mask = (nb == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << nb) - 64'd1);
        ena  = (o == 3'd2) || (o == 3'd3) || (o == 3'd6) || (o == 3'd7);
        sub  = (o == 3'd1) || (o == 3'd3) || (o == 3'd5) || (o == 3'd7);
        ci   = (o == 3'd1) || (o == 3'd3) || (o == 3'd4) || (o >= 3'd6 && cin);
        s    = {1'b0, ena ? (av & mask) : 64'd0} + {1'b0, (sub ? ~bv : bv) & mask} + {64'd0, ci};
        ra   = s[63:0] & mask;
        return {s[nb], (ra == 64'd0), ra[nb-1], ra};
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [1:0] l, input logic [63:0] av,
                         input logic [63:0] bv, input bit hold_start, output logic [63:0] y_obs);
        logic [66:0] exp;
        int cyc;
        exp = model(o, l, av, bv, m_cf);
        @(negedge clk);
        op = o; len = l; a = av; b = bv; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        op = 3'($urandom); len = 2'($urandom);
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        cyc = 1;
        while (!done && cyc < 10) begin
            n_tests++;
            if (busy !== 1'b1) begin
                n_fail++; $display("FAIL busy_run: got %b want 1 (cycle %0d)", busy, cyc);
            end
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (cyc !== int'(l) + 2) begin
            n_fail++; $display("FAIL done_latency: got %0d want %0d", cyc, int'(l) + 2);
        end
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_fin: got %b want 1", busy); end
        n_tests++;
        if (y !== exp[63:0]) begin
            n_fail++; $display("FAIL y op=%0d len=%0d: got %h want %h", o, l, y, exp[63:0]);
        end
        n_tests++;
        if ({cf, zf, nf} !== exp[66:64]) begin
            n_fail++; $display("FAIL flags op=%0d len=%0d: got cf/zf/nf %b want %b", o, l, {cf, zf, nf}, exp[66:64]);
        end
        y_obs = y;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if ({done, busy} !== 2'b00) begin
            n_fail++; $display("FAIL after_fin: got done/busy %b want 00", {done, busy});
        end
        n_tests++;
        if (y !== exp[63:0] || cf !== exp[66]) begin
            n_fail++; $display("FAIL hold: got y=%h cf=%b want y=%h cf=%b", y, cf, exp[63:0], exp[66]);
        end
        m_cf = exp[66];
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({busy, done, cf, zf, nf} !== 5'b0 || y !== 64'd0) begin
            n_fail++; $display("FAIL reset_state: got b/d/c/z/n %b y=%h want 0", {busy, done, cf, zf, nf}, y);
        end
        rstn = 1'b1;
        m_cf = 1'b0;
    endtask

    task automatic test_directed();
        logic [63:0] yo;
        logic [63:0] exp_all [8];
        exp_all = '{64'd3333, 64'hF2FB, 64'd9999, 64'd3333, 64'd3334, 64'hF2FA, 64'd9999, 64'd3332};
        do_op(3'd2, 2'd0, 64'd6666, 64'd3333, 1'b0, yo);
        do_op(3'd2, 2'd3, 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, yo);
        n_tests++;
        if (yo !== 64'h0000_0000_0001_0000) begin n_fail++; $display("FAIL add64: got %h want 0000000000010000", yo); end
        do_op(3'd3, 2'd3, 64'd0, 64'd1, 1'b0, yo);
        n_tests++;
        if ({yo, cf, nf, zf} !== {64'hFFFF_FFFF_FFFF_FFFF, 3'b010}) begin
            n_fail++; $display("FAIL sub64: got y=%h cf/nf/zf=%b want all-ones 010", yo, {cf, nf, zf});
        end
        do_op(3'd1, 2'd1, 64'd0, 64'd0, 1'b0, yo);
        n_tests++;
        if ({yo, cf, zf} !== {64'd0, 2'b11}) begin n_fail++; $display("FAIL neg0: got y=%h cf/zf=%b want 0 11", yo, {cf, zf}); end
        do_op(3'd2, 2'd0, 64'hFFFF, 64'd1, 1'b0, yo);
        n_tests++;
        if ({yo, cf, zf} !== {64'd0, 2'b11}) begin n_fail++; $display("FAIL add_wrap: got y=%h cf/zf=%b want 0 11", yo, {cf, zf}); end
        do_op(3'd6, 2'd0, 64'd0, 64'd0, 1'b0, yo);
        n_tests++;
        if ({yo, cf} !== {64'd1, 1'b0}) begin n_fail++; $display("FAIL adc: got y=%h cf=%b want 1 0", yo, cf); end
        do_op(3'd7, 2'd0, 64'd5, 64'd2, 1'b0, yo);
        n_tests++;
        if ({yo, cf} !== {64'd2, 1'b1}) begin n_fail++; $display("FAIL sbc: got y=%h cf=%b want 2 1", yo, cf); end
        for (int i = 0; i < 8; i++) begin
            if (m_cf) do_op(3'd0, 2'd0, 64'd0, 64'd0, 1'b0, yo);  // MOV 0 clears CF
            do_op(3'(i), 2'd0, 64'd6666, 64'd3333, 1'b0, yo);
            n_tests++;
            if (yo !== exp_all[i]) begin n_fail++; $display("FAIL op_table op=%0d: got %h want %h", i, yo, exp_all[i]); end
        end
    endtask

    task automatic test_random();
        logic [63:0] yo;
        for (int i = 0; i < 40; i++)
            do_op(3'($urandom), 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, yo);
    endtask

    task automatic test_back_to_back();
        logic [63:0] yo;
        do_op(3'd2, 2'd3, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, yo);
        do_op(3'd3, 2'd2, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, yo);
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] yo;
        do_op(3'd1, 2'd3, 64'd0, 64'd5, 1'b0, yo);
        @(negedge clk);
        op = 3'd2; len = 2'd3; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, cf, zf, nf} !== 5'b0 || y !== 64'd0) begin
            n_fail++; $display("FAIL reset_mid_run: got b/d/c/z/n %b y=%h want 0", {busy, done, cf, zf, nf}, y);
        end
        @(negedge clk);
        rstn = 1'b1;
        m_cf = 1'b0;
        do_op(3'd6, 2'd1, 64'd7, 64'd9, 1'b0, yo);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
